// File: rtl/canvas_draw_engine.sv
// Cell-based drawing canvas: cursor movement, brush stamps, canvas clear,
// continuous VGA refresh and a handshaked raster readout of every cell.
module canvas_draw_engine #(
   parameter int GRID_W       = 28,
   parameter int GRID_H       = 28,
   parameter int CELL_LOG2    = 2,
   parameter int PIX_BITS     = 4,
   parameter int REPEAT_DELAY = 2000000,
   parameter int XW           = $clog2(GRID_W),
   parameter int YW           = $clog2(GRID_H)
) (
   input  logic                CLOCK_50,
   input  logic                reset,
   input  logic                move_up,
   input  logic                move_down,
   input  logic                move_left,
   input  logic                move_right,
   input  logic                pen_en,
   input  logic [1:0]          brush_mode,
   output logic [XW-1:0]       cur_x,
   output logic [YW-1:0]       cur_y,
   output logic [7:0]          vga_x,
   output logic [6:0]          vga_y,
   output logic [2:0]          vga_colour,
   output logic                vga_plot,
   input  logic                rd_start,
   output logic [PIX_BITS-1:0] rd_data,
   output logic                rd_valid,
   input  logic                rd_ready,
   output logic                rd_last,
   output logic                rd_busy
);
   localparam int N    = GRID_W * GRID_H;
   localparam int AW   = $clog2(N);
   localparam int MAXV = 2**PIX_BITS - 1;
   localparam int HALF = 2**(PIX_BITS-1);
   localparam int RW   = $clog2(REPEAT_DELAY + 1);
   localparam int PXW  = GRID_W << CELL_LOG2;
   localparam int PYH  = GRID_H << CELL_LOG2;

   if (PXW > 160 || PYH > 120) begin : g_size_chk
      $error("canvas does not fit the 160x120 VGA frame");
   end

   typedef enum logic [1:0] {S_CLEAR, S_IDLE, S_PAINT, S_READ} state_t;
   state_t r_state, w_next;

   logic [PIX_BITS-1:0] r_mem [N];
   logic [PIX_BITS-1:0] r_rda, r_rdb, w_wdata, w_sat;
   logic [PIX_BITS:0]   w_sum;
   logic [AW-1:0]       w_waddr, w_raddr, w_baddr, w_naddr, w_caddr, r_clr, r_idx;
   logic                w_we;
   logic [XW-1:0]       r_cx, r_lx, r_sx, w_nx;
   logic [YW-1:0]       r_cy, r_ly, r_sy, w_ny;
   logic [RW-1:0]       r_rep;
   logic                r_pen_d, r_pend, w_pen_rise, w_moved, w_trig, w_clr_req, w_start_stamp;
   logic [1:0]          r_mode;
   logic [2:0]          r_step;
   logic                r_ph, w_nok, w_nbr_done;
   logic                r_rvld, w_fire, w_last;
   logic [7:0]          r_hx, r_x1;
   logic [6:0]          r_hy, r_y1;
   logic                r_c1, w_iscur;
   logic [2:0]          w_col;

   always_ff @(posedge CLOCK_50) begin
      if (w_we) r_mem[w_waddr] <= w_wdata;
      r_rda <= r_mem[w_raddr];
      r_rdb <= r_mem[w_baddr];
   end

   // Cursor with auto-repeat; opposing directions cancel per axis.
   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         r_cx  <= XW'(GRID_W / 2);
         r_cy  <= YW'(GRID_H / 2);
         r_rep <= '0;
      end else if (r_state == S_CLEAR || !(move_up | move_down | move_left | move_right)) begin
         r_rep <= '0;
      end else if (r_rep == '0) begin
         r_rep <= RW'(REPEAT_DELAY - 1);
         if (move_right && !move_left && r_cx != XW'(GRID_W - 1)) r_cx <= r_cx + 1'b1;
         else if (move_left && !move_right && r_cx != '0)        r_cx <= r_cx - 1'b1;
         if (move_down && !move_up && r_cy != YW'(GRID_H - 1))   r_cy <= r_cy + 1'b1;
         else if (move_up && !move_down && r_cy != '0)           r_cy <= r_cy - 1'b1;
      end else begin
         r_rep <= r_rep - 1'b1;
      end
   end

   assign w_pen_rise    = pen_en & ~r_pen_d;
   assign w_moved       = (r_cx != r_lx) || (r_cy != r_ly);
   assign w_trig        = (w_pen_rise | (w_moved & pen_en)) & (brush_mode != 2'd3);
   assign w_clr_req     = w_pen_rise & (brush_mode == 2'd3);
   assign w_start_stamp = (r_state == S_IDLE) && !rd_start && !w_clr_req &&
                          (w_trig || r_pend) && (brush_mode != 2'd3);

   // A trigger arriving mid-stamp is held so it is not lost; READ/CLEAR drop it.
   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         r_pen_d <= 1'b0;
         r_lx    <= XW'(GRID_W / 2);
         r_ly    <= YW'(GRID_H / 2);
         r_pend  <= 1'b0;
      end else begin
         r_pen_d <= pen_en;
         r_lx    <= r_cx;
         r_ly    <= r_cy;
         if (r_state == S_CLEAR || r_state == S_READ || w_start_stamp) r_pend <= 1'b0;
         else if (w_trig)                                             r_pend <= 1'b1;
      end
   end

   // Neighbour walk for the soft brush: step 1..4 = N, S, W, E.
   always_comb begin
      w_nx  = r_sx;
      w_ny  = r_sy;
      w_nok = 1'b0;
      case (r_step)
         3'd1: begin w_nok = (r_sy != '0);                w_ny = r_sy - 1'b1; end
         3'd2: begin w_nok = (r_sy != YW'(GRID_H - 1));   w_ny = r_sy + 1'b1; end
         3'd3: begin w_nok = (r_sx != '0);                w_nx = r_sx - 1'b1; end
         3'd4: begin w_nok = (r_sx != XW'(GRID_W - 1));   w_nx = r_sx + 1'b1; end
         default: ;
      endcase
   end

   assign w_naddr    = AW'(32'(w_ny) * GRID_W + 32'(w_nx));
   assign w_caddr    = AW'(32'(r_sy) * GRID_W + 32'(r_sx));
   assign w_nbr_done = (r_step != 3'd0) && (!w_nok || r_ph);
   assign w_sum      = {1'b0, r_rda} + (PIX_BITS+1)'(HALF);
   assign w_sat      = (w_sum > (PIX_BITS+1)'(MAXV)) ? PIX_BITS'(MAXV) : w_sum[PIX_BITS-1:0];

   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         r_sx   <= '0;
         r_sy   <= '0;
         r_mode <= '0;
         r_step <= '0;
         r_ph   <= 1'b0;
      end else if (w_start_stamp) begin
         r_sx   <= r_cx;
         r_sy   <= r_cy;
         r_mode <= brush_mode;
         r_step <= '0;
         r_ph   <= 1'b0;
      end else if (r_state == S_PAINT) begin
         if (r_step == 3'd0 || w_nbr_done) begin
            r_step <= r_step + 1'b1;
            r_ph   <= 1'b0;
         end else begin
            r_ph   <= 1'b1;
         end
      end
   end

   assign w_fire = r_rvld & rd_ready;
   assign w_last = r_rvld && (r_idx == AW'(N - 1));

   always_ff @(posedge CLOCK_50) begin
      if (reset) r_state <= S_CLEAR;
      else       r_state <= w_next;
   end

   always_comb begin
      w_next  = r_state;
      w_we    = 1'b0;
      w_waddr = r_clr;
      w_wdata = '0;
      w_raddr = r_idx;
      case (r_state)
         S_CLEAR: begin
            w_we = 1'b1;
            if (r_clr == AW'(N - 1)) w_next = S_IDLE;
         end
         S_IDLE: begin
            w_raddr = '0;
            if (rd_start)           w_next = S_READ;
            else if (w_clr_req)     w_next = S_CLEAR;
            else if (w_start_stamp) w_next = S_PAINT;
         end
         S_PAINT: begin
            w_raddr = w_naddr;
            if (r_step == 3'd0) begin
               w_we    = 1'b1;
               w_waddr = w_caddr;
               w_wdata = (r_mode == 2'd2) ? '0 : PIX_BITS'(MAXV);
            end else if (w_nok && r_ph) begin
               w_we    = 1'b1;
               w_waddr = w_naddr;
               w_wdata = w_sat;
            end
            if ((r_step == 3'd0 && r_mode != 2'd1) || (r_step == 3'd4 && w_nbr_done))
               w_next = S_IDLE;
         end
         S_READ: begin
            // Look ahead on a handshake so the next cell lands without a bubble.
            w_raddr = (w_fire && !w_last) ? r_idx + 1'b1 : r_idx;
            if (w_fire && w_last) w_next = S_IDLE;
         end
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge CLOCK_50) begin
      if (reset || r_state != S_CLEAR) r_clr <= '0;
      else                             r_clr <= r_clr + 1'b1;
   end

   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         r_rvld <= 1'b0;
         r_idx  <= '0;
      end else if (r_state == S_IDLE && rd_start) begin
         r_rvld <= 1'b1;
         r_idx  <= '0;
      end else if (r_state == S_READ && w_fire) begin
         if (w_last) r_rvld <= 1'b0;
         else        r_idx  <= r_idx + 1'b1;
      end
   end

   assign cur_x    = r_cx;
   assign cur_y    = r_cy;
   assign rd_data  = r_rda;
   assign rd_valid = r_rvld;
   assign rd_last  = w_last;
   assign rd_busy  = (r_state == S_READ);

   // Render: scanner -> memory read + cursor compare -> registered VGA outputs.
   assign w_baddr = AW'(32'(r_hy >> CELL_LOG2) * GRID_W + 32'(r_hx >> CELL_LOG2));
   assign w_iscur = (32'(r_hx >> CELL_LOG2) == 32'(r_cx)) && (32'(r_hy >> CELL_LOG2) == 32'(r_cy));

   always_comb begin
      if (r_c1)                               w_col = 3'b100;
      else if (r_rdb >= PIX_BITS'(HALF))      w_col = 3'b111;
      else if (r_rdb != '0)                   w_col = 3'b010;
      else                                    w_col = 3'b001;
   end

   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         r_hx <= '0;  r_hy <= '0;
         r_x1 <= '0;  r_y1 <= '0;  r_c1 <= 1'b0;
         vga_x <= '0; vga_y <= '0; vga_colour <= '0; vga_plot <= 1'b0;
      end else begin
         if (r_hx == 8'(PXW - 1)) begin
            r_hx <= '0;
            r_hy <= (r_hy == 7'(PYH - 1)) ? '0 : r_hy + 1'b1;
         end else begin
            r_hx <= r_hx + 1'b1;
         end
         r_x1       <= r_hx;
         r_y1       <= r_hy;
         r_c1       <= w_iscur;
         vga_x      <= r_x1;
         vga_y      <= r_y1;
         vga_colour <= w_col;
         vga_plot   <= 1'b1;
      end
   end
endmodule

// File: tb/tb_canvas_draw_engine.sv
// Directed bench for canvas_draw_engine: reset, readout, brushes, cursor
// movement, readout backpressure and VGA colour rendering.
module tb_canvas_draw_engine;
   localparam int N = 784;

   logic       clk = 1'b0;
   logic       reset, move_up, move_down, move_left, move_right, pen_en, rd_start, rd_ready;
   logic [1:0] brush_mode;
   logic [4:0] cur_x, cur_y;
   logic [7:0] vga_x;
   logic [6:0] vga_y;
   logic [2:0] vga_colour;
   logic       vga_plot, rd_valid, rd_last, rd_busy;
   logic [3:0] rd_data;

   int n_chk = 0;
   int n_err = 0;
   int img [N];
   int exp_img [N];
   int cx, cy, e, bad, c1, c4, c7, mx, my;

   always #5 clk = ~clk;

   canvas_draw_engine #(.REPEAT_DELAY(4)) dut (
      .CLOCK_50(clk), .reset(reset),
      .move_up(move_up), .move_down(move_down), .move_left(move_left), .move_right(move_right),
      .pen_en(pen_en), .brush_mode(brush_mode),
      .cur_x(cur_x), .cur_y(cur_y),
      .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour), .vga_plot(vga_plot),
      .rd_start(rd_start), .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready),
      .rd_last(rd_last), .rd_busy(rd_busy)
   );

   task automatic chk(input string tag, input int got, input int exp);
      n_chk++;
      if (got != exp) begin
         n_err++;
         $display("FAIL %s got %0d exp %0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic cmp_img(input string tag);
      int m;
      m = 0;
      for (int i = 0; i < N; i++) if (img[i] != exp_img[i]) m++;
      chk(tag, m, 0);
   endtask

   // dir: 0 up, 1 down, 2 left, 3 right
   task automatic hold_until(input int dir, input int target);
      int n;
      n = 0;
      move_up = (dir == 0); move_down = (dir == 1);
      move_left = (dir == 2); move_right = (dir == 3);
      while (((dir < 2) ? int'(cur_y) : int'(cur_x)) != target && n < 400) begin
         tick();
         n++;
      end
      move_up = 0; move_down = 0; move_left = 0; move_right = 0;
      tick();
      chk("move_reach", (dir < 2) ? int'(cur_y) : int'(cur_x), target);
   endtask

   task automatic pen_stamp(input logic [1:0] mode, input int hold);
      brush_mode = mode;
      pen_en = 1;
      repeat (hold) tick();
      pen_en = 0;
      tick();
   endtask

   task automatic do_read(input bit stall);
      int c, beats, lastc, lasti, viol;
      bit pv_stall;
      int pdata;
      c = 0; beats = 0; lastc = 0; lasti = -1; viol = 0; pv_stall = 0; pdata = 0;
      rd_start = 1;
      tick();
      rd_start = 0;
      chk("rd_busy_on", int'(rd_busy), 1);
      while (beats < N && c < 6000) begin
         if (stall) begin
            rd_ready = (c >= 20 && c < 25) ? 1'b0 : (c % 2 == 0);
            rd_start = (c == 30);
            if (c == 40) begin brush_mode = 0; pen_en = 1; end
            if (c == 45) pen_en = 0;
            if (c == 50) chk("rd_busy_mid", int'(rd_busy), 1);
         end else begin
            rd_ready = 1;
         end
         if (pv_stall && (!rd_valid || int'(rd_data) != pdata)) viol++;
         if (rd_valid && rd_ready) begin
            img[beats] = int'(rd_data);
            if (rd_last) begin lastc++; lasti = beats; end
            beats++;
         end
         pv_stall = rd_valid && !rd_ready;
         pdata = int'(rd_data);
         tick();
         c++;
      end
      rd_ready = 0;
      rd_start = 0;
      pen_en = 0;
      chk("rd_beats", beats, N);
      chk("rd_last_count", lastc, 1);
      chk("rd_last_index", lasti, N - 1);
      if (stall) chk("rd_stall_stable", viol, 0);
      tick();
      chk("rd_busy_off", int'(rd_busy), 0);
      chk("rd_valid_off", int'(rd_valid), 0);
   endtask

   initial begin
      reset = 1; move_up = 0; move_down = 0; move_left = 0; move_right = 0;
      pen_en = 0; brush_mode = 0; rd_start = 0; rd_ready = 0;
      for (int i = 0; i < N; i++) exp_img[i] = 0;

      // 1: reset state, clear sweep, all-zero readout
      tick();
      chk("rst_cur_x", int'(cur_x), 14);
      chk("rst_cur_y", int'(cur_y), 14);
      chk("rst_rd_valid", int'(rd_valid), 0);
      chk("rst_rd_last", int'(rd_last), 0);
      chk("rst_rd_busy", int'(rd_busy), 0);
      chk("rst_vga_plot", int'(vga_plot), 0);
      chk("rst_vga_xyc", int'(vga_x) + int'(vga_y) + int'(vga_colour), 0);
      reset = 0;
      repeat (790) tick();
      do_read(0);
      cmp_img("t1_img_zero");

      // 2: pen stamp at the centre
      pen_stamp(2'd0, 3);
      do_read(0);
      exp_img[406] = 15;
      cmp_img("t2_img");
      chk("t2_cell406", img[406], 15);

      // 3: soft brush at the corner, then a second edge saturates neighbours
      hold_until(2, 0);
      hold_until(0, 0);
      move_left = 1; move_up = 1;
      repeat (10) tick();
      move_left = 0; move_up = 0;
      tick();
      chk("t3_sat_x0", int'(cur_x), 0);
      chk("t3_sat_y0", int'(cur_y), 0);
      pen_stamp(2'd1, 12);
      do_read(0);
      exp_img[0] = 15; exp_img[1] = 8; exp_img[28] = 8;
      cmp_img("t3_soft1");
      chk("t3_right_nbr", img[1], 8);
      pen_stamp(2'd1, 12);
      do_read(0);
      exp_img[1] = 15; exp_img[28] = 15;
      cmp_img("t3_soft2");

      // 4: saturation at the right edge and cancelling opposites
      hold_until(3, 26);
      move_right = 1;
      tick();
      chk("t4_first_step", int'(cur_x), 27);
      repeat (19) tick();
      chk("t4_hold_sat", int'(cur_x), 27);
      move_right = 0;
      tick();
      hold_until(1, 5);
      move_up = 1; move_down = 1;
      repeat (12) tick();
      chk("t4_ud_cancel", int'(cur_y), 5);
      move_up = 0; move_down = 0; move_left = 1; move_right = 1;
      repeat (12) tick();
      chk("t4_lr_cancel", int'(cur_x), 27);
      move_left = 0; move_right = 0;
      tick();

      // 5: backpressured readout; rd_start and a pen stamp during READ ignored
      do_read(1);
      cmp_img("t5_stall_img");
      repeat (5) tick();
      do_read(0);
      cmp_img("t5_after_img");
      chk("t5_dropped_stamp", img[167], 0);

      // 6: clear, one full cell at (3,2), cursor at (0,0), check one VGA frame
      brush_mode = 2'd3;
      pen_en = 1;
      tick();
      pen_en = 0;
      repeat (800) tick();
      hold_until(2, 3);
      hold_until(0, 2);
      pen_stamp(2'd0, 3);
      hold_until(2, 0);
      hold_until(0, 0);
      repeat (4) tick();
      bad = 0; c1 = 0; c4 = 0; c7 = 0; mx = 0; my = 0;
      for (int i = 0; i < 112 * 112; i++) begin
         cx = int'(vga_x) >> 2;
         cy = int'(vga_y) >> 2;
         e = (cx == 0 && cy == 0) ? 4 : (cx == 3 && cy == 2) ? 7 : 1;
         if (int'(vga_x) >= 112 || int'(vga_y) >= 112 || int'(vga_colour) != e || !vga_plot) bad++;
         if (vga_colour == 3'b100) c4++;
         if (vga_colour == 3'b111) c7++;
         if (vga_colour == 3'b001) c1++;
         if (int'(vga_x) > mx) mx = int'(vga_x);
         if (int'(vga_y) > my) my = int'(vga_y);
         tick();
      end
      chk("t6_pix_bad", bad, 0);
      chk("t6_cursor_px", c4, 16);
      chk("t6_full_px", c7, 16);
      chk("t6_empty_px", c1, 112 * 112 - 32);
      chk("t6_max_x", mx, 111);
      chk("t6_max_y", my, 111);

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end
endmodule
